// File: rtl/top_memory_access.sv
// rtl/top_memory_access.sv - memory-access stage: issues load/store on a req/ack bus and fills the mw latch
module top_memory_access #(
    parameter int XLEN         = 32,
    parameter int OPLEN        = 16,
    parameter int LOAD_BIT     = 0,
    parameter int STORE_BIT    = 1,
    parameter int SIZE_LSB     = 2,
    parameter int UNSIGNED_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             phase_memory,
    input  logic [OPLEN-1:0] decoded_op_em,
    input  logic             jump_state_em,
    input  logic [4:0]       rdsel_em,
    input  logic [XLEN-1:0]  next_pc_em,
    input  logic [XLEN-1:0]  alu_out_em,
    input  logic [XLEN-1:0]  rs2data_em,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic [XLEN-1:0]  dmem_rdata,
    input  logic             dmem_ack,
    output logic [OPLEN-1:0] decoded_op_mw,
    output logic             jump_state_mw,
    output logic [4:0]       rdsel_mw,
    output logic [XLEN-1:0]  next_pc_mw,
    output logic [XLEN-1:0]  alu_out_mw,
    output logic [XLEN-1:0]  mem_rdata_mw,
    output logic             misalign_mw,
    output logic             stall_memory
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state_q, state_d;

    logic             req_q, we_q;
    logic [XLEN-1:0]  addr_q, wdata_q;
    logic [3:0]       be_q;
    logic [OPLEN-1:0] op_q;
    logic             jump_q;
    logic [4:0]       rdsel_q;
    logic [XLEN-1:0]  npc_q, alu_q;

    logic             start, idle_done, busy_done;

    // Decode of the incoming execute bundle
    logic             is_store, is_access, misalign;
    logic [1:0]       size_em, lane_em;
    logic [3:0]       be_st;
    logic [XLEN-1:0]  wdata_st;

    always_comb begin
        is_store  = decoded_op_em[STORE_BIT];
        is_access = decoded_op_em[LOAD_BIT] | decoded_op_em[STORE_BIT];
        size_em   = decoded_op_em[SIZE_LSB +: 2];
        lane_em   = alu_out_em[1:0];
        misalign  = is_access &
                    (((size_em == 2'b01) & lane_em[0]) | (size_em[1] & (lane_em != 2'b00)));
        case (size_em)
            2'b00: begin
                wdata_st = {4{rs2data_em[7:0]}};
                be_st    = 4'b0001 << lane_em;
            end
            2'b01: begin
                wdata_st = {2{rs2data_em[15:0]}};
                be_st    = 4'b0011 << lane_em;
            end
            default: begin
                wdata_st = rs2data_em;
                be_st    = 4'b1111;
            end
        endcase
    end

    // Load extraction uses the captured op and address, not the live em inputs
    logic [1:0]       size_q;
    logic             uns_q, load_only_q;
    logic [XLEN-1:0]  shifted, load_ext;

    always_comb begin
        size_q      = op_q[SIZE_LSB +: 2];
        uns_q       = op_q[UNSIGNED_BIT];
        load_only_q = op_q[LOAD_BIT] & ~op_q[STORE_BIT];
        shifted     = dmem_rdata >> {alu_q[1:0], 3'b000};
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (phase_memory && is_access && !misalign) state_d = BUSY;
            BUSY:    if (dmem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start        = 1'b0;
        idle_done    = 1'b0;
        busy_done    = 1'b0;
        stall_memory = 1'b0;
        case (state_q)
            IDLE: begin
                start        = phase_memory & is_access & ~misalign;
                idle_done    = phase_memory & ~(is_access & ~misalign);
                stall_memory = start;
            end
            BUSY: begin
                busy_done    = dmem_ack;
                stall_memory = ~dmem_ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            jump_q  <= 1'b0;
            rdsel_q <= '0;
            npc_q   <= '0;
            alu_q   <= '0;
        end else if (start) begin
            req_q   <= 1'b1;
            we_q    <= is_store;
            addr_q  <= {alu_out_em[XLEN-1:2], 2'b00};
            be_q    <= is_store ? be_st : 4'b1111;
            wdata_q <= is_store ? wdata_st : '0;
            op_q    <= decoded_op_em;
            jump_q  <= jump_state_em;
            rdsel_q <= rdsel_em;
            npc_q   <= next_pc_em;
            alu_q   <= alu_out_em;
        end else if (busy_done) begin
            req_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decoded_op_mw <= '0;
            jump_state_mw <= 1'b0;
            rdsel_mw      <= '0;
            next_pc_mw    <= '0;
            alu_out_mw    <= '0;
            mem_rdata_mw  <= '0;
            misalign_mw   <= 1'b0;
        end else if (idle_done) begin
            decoded_op_mw <= decoded_op_em;
            jump_state_mw <= jump_state_em;
            rdsel_mw      <= rdsel_em;
            next_pc_mw    <= next_pc_em;
            alu_out_mw    <= alu_out_em;
            mem_rdata_mw  <= '0;
            misalign_mw   <= misalign;
        end else if (busy_done) begin
            decoded_op_mw <= op_q;
            jump_state_mw <= jump_q;
            rdsel_mw      <= rdsel_q;
            next_pc_mw    <= npc_q;
            alu_out_mw    <= alu_q;
            mem_rdata_mw  <= load_only_q ? load_ext : '0;
            misalign_mw   <= 1'b0;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_top_memory_access.sv
// tb/tb_top_memory_access.sv - directed and random checks of top_memory_access against a behavioural model
module tb_top_memory_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        phase_memory = 1'b0;
    logic [15:0] decoded_op_em = '0;
    logic        jump_state_em = 1'b0;
    logic [4:0]  rdsel_em = '0;
    logic [31:0] next_pc_em = '0, alu_out_em = '0, rs2data_em = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic [15:0] decoded_op_mw;
    logic        jump_state_mw;
    logic [4:0]  rdsel_mw;
    logic [31:0] next_pc_mw, alu_out_mw, mem_rdata_mw;
    logic        misalign_mw, stall_memory;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] e_op;
    logic        e_jump, e_mis;
    logic [4:0]  e_rdsel;
    logic [31:0] e_npc, e_alu, e_rdata;

    top_memory_access dut (
        .clk(clk), .rst_n(rst_n), .phase_memory(phase_memory),
        .decoded_op_em(decoded_op_em), .jump_state_em(jump_state_em), .rdsel_em(rdsel_em),
        .next_pc_em(next_pc_em), .alu_out_em(alu_out_em), .rs2data_em(rs2data_em),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .decoded_op_mw(decoded_op_mw), .jump_state_mw(jump_state_mw), .rdsel_mw(rdsel_mw),
        .next_pc_mw(next_pc_mw), .alu_out_mw(alu_out_mw), .mem_rdata_mw(mem_rdata_mw),
        .misalign_mw(misalign_mw), .stall_memory(stall_memory)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_mw(input string tag);
        chk({tag, ".op"}, 32'(decoded_op_mw), 32'(e_op));
        chk({tag, ".jump"}, 32'(jump_state_mw), 32'(e_jump));
        chk({tag, ".rdsel"}, 32'(rdsel_mw), 32'(e_rdsel));
        chk({tag, ".npc"}, next_pc_mw, e_npc);
        chk({tag, ".alu"}, alu_out_mw, e_alu);
        chk({tag, ".rdata"}, mem_rdata_mw, e_rdata);
        chk({tag, ".misalign"}, 32'(misalign_mw), 32'(e_mis));
    endtask

    // Access width in bytes; reserved size behaves as a word
    function automatic int nbytes(input logic [15:0] op);
        int sz = int'(op[3:2]);
        return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [15:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int n = nbytes(op);
        longint v;
        if (n == 4) return rdata;
        v = (longint'(rdata) >> (8 * (addr % 4))) % (64'sd1 << (8 * n));
        if (!op[4] && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [15:0] op, input logic [31:0] addr);
        int n = nbytes(op);
        int v = ((1 << n) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [15:0] op, input logic [31:0] rs2);
        int n = nbytes(op);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % n) +: 8];
        return w;
    endfunction

    task automatic scramble();
        decoded_op_em = 16'($urandom);
        jump_state_em = 1'($urandom);
        rdsel_em      = 5'($urandom);
        next_pc_em    = $urandom;
        alu_out_em    = $urandom;
        rs2data_em    = $urandom;
    endtask

    task automatic do_op(input string tag, input logic [15:0] op, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic jmp,
                         input logic [31:0] npc, input int w_cycles, input logic [31:0] rdata,
                         input bit busy_phase);
        bit store = op[1];
        bit acc   = op[0] | op[1];
        bit mis   = acc && ((addr % nbytes(op)) != 0);
        decoded_op_em = op; alu_out_em = addr; rs2data_em = rs2;
        rdsel_em = rd; jump_state_em = jmp; next_pc_em = npc;
        phase_memory = 1'b1;
        #1;
        chk({tag, ".stall_P"}, 32'(stall_memory), 32'(acc && !mis));
        chk({tag, ".req_P"}, 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        phase_memory = 1'b0;
        scramble();
        e_op = op; e_jump = jmp; e_rdsel = rd; e_npc = npc; e_alu = addr;
        if (!acc || mis) begin
            e_rdata = '0; e_mis = mis;
            check_mw(tag);
            chk({tag, ".req_none"}, 32'(dmem_req), 32'd0);
            return;
        end
        for (int w = 0; w <= w_cycles; w++) begin
            chk({tag, ".req"}, 32'(dmem_req), 32'd1);
            chk({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
            chk({tag, ".we"}, 32'(dmem_we), 32'(store));
            chk({tag, ".be"}, 32'(dmem_be), store ? 32'(ref_be(op, addr)) : 32'hF);
            if (store) chk({tag, ".wdata"}, dmem_wdata, ref_wdata(op, rs2));
            if (w == w_cycles) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
            else begin dmem_ack = 1'b0; dmem_rdata = $urandom; end
            if (busy_phase) phase_memory = 1'($urandom);
            #1;
            chk({tag, ".stall_busy"}, 32'(stall_memory), 32'(w != w_cycles));
            @(posedge clk); #1;
            phase_memory = 1'b0;
        end
        dmem_ack = 1'b0;
        e_rdata = (op[0] && !op[1]) ? ref_load(op, addr, rdata) : 32'd0;
        e_mis = 1'b0;
        check_mw(tag);
        chk({tag, ".req_drop"}, 32'(dmem_req), 32'd0);
    endtask

    initial begin
        e_op = '0; e_jump = 1'b0; e_rdsel = '0; e_npc = '0; e_alu = '0; e_rdata = '0; e_mis = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_mw("reset");
        chk("reset.req", 32'(dmem_req), 32'd0);
        chk("reset.we", 32'(dmem_we), 32'd0);
        chk("reset.be", 32'(dmem_be), 32'd0);
        chk("reset.addr", dmem_addr, 32'd0);
        chk("reset.wdata", dmem_wdata, 32'd0);
        chk("reset.stall", 32'(stall_memory), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("lw",   16'h0009, 32'h100, 32'h0, 5'd1, 1'b0, 32'h1004, 3, 32'hDEADBEEF, 1'b0);
        do_op("lb",   16'h0001, 32'h103, 32'h0, 5'd2, 1'b0, 32'h1008, 1, 32'h80123456, 1'b0);
        do_op("lbu",  16'h0011, 32'h103, 32'h0, 5'd3, 1'b0, 32'h100C, 0, 32'h80123456, 1'b0);
        do_op("lh",   16'h0005, 32'h102, 32'h0, 5'd4, 1'b0, 32'h1010, 2, 32'h80123456, 1'b0);
        do_op("sh",   16'h0006, 32'h102, 32'h1234ABCD, 5'd5, 1'b0, 32'h1014, 0, 32'h0, 1'b0);
        do_op("lwmis", 16'h0009, 32'h102, 32'h0, 5'd6, 1'b0, 32'h1018, 0, 32'h0, 1'b0);
        do_op("sw",   16'h000A, 32'h104, 32'hCAFEF00D, 5'd0, 1'b1, 32'h101C, 1, 32'h0, 1'b0);
        do_op("nop",  16'h0120, 32'h55, 32'h0, 5'd7, 1'b1, 32'h1020, 0, 32'h0, 1'b0);
        do_op("phbusy", 16'h0009, 32'h200, 32'h0, 5'd8, 1'b0, 32'h1024, 3, 32'h01020304, 1'b1);

        // Reset while a request is outstanding
        decoded_op_em = 16'h0009; alu_out_em = 32'h300; phase_memory = 1'b1;
        @(posedge clk); #1;
        phase_memory = 1'b0;
        chk("rst.req_before", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        e_op = '0; e_jump = 1'b0; e_rdsel = '0; e_npc = '0; e_alu = '0; e_rdata = '0; e_mis = 1'b0;
        chk("rst.req_after", 32'(dmem_req), 32'd0);
        check_mw("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'hBADBAD00;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("late_ack.req", 32'(dmem_req), 32'd0);
        check_mw("late_ack");
        do_op("post_rst", 16'h0009, 32'h300, 32'h0, 5'd9, 1'b0, 32'h2000, 1, 32'h76543210, 1'b0);

        for (int i = 0; i < 150; i++) begin
            logic [15:0] op = 16'($urandom);
            op[1:0] = 2'($urandom_range(0, 3));
            do_op("rand", op, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
                  $urandom_range(0, 3), $urandom, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/top_memory_access.md
# top_memory_access

Memory-access pipeline stage sitting directly downstream of the execute stage. It consumes the execute→memory latch bundle (`*_em` signals) and issues load/store transactions on a request/acknowledge data-memory bus with arbitrary wait states, stalling the state machine until the transaction completes. It aligns store data into byte lanes and extracts/extends load data. Results are registered into the memory→writeback latch (`*_mw` signals).

## Interface
- XLEN, 32, datapath width; only 32 is supported, giving 4 byte lanes.
- OPLEN, 16, decoded-op width.
- LOAD_BIT, 0, bit index in decoded_op marking a load.
- STORE_BIT, 1, bit index in decoded_op marking a store.
- SIZE_LSB, 2, LSB of the 2-bit access-size field: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- UNSIGNED_BIT, 4, bit index in decoded_op marking a zero-extended load.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- phase_memory  in  1  memory phase strobe from the state machine
- decoded_op_em  in  OPLEN  decoded opcode
- jump_state_em  in  1  jump-taken flag
- rdsel_em  in  5  destination register
- next_pc_em  in  XLEN  next PC
- alu_out_em  in  XLEN  ALU result; the effective address for load/store
- rs2data_em  in  XLEN  store source
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  XLEN  word-aligned address ({alu_out[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_rdata  in  XLEN  read data, valid with ack
- dmem_ack  in  1  transaction complete
- decoded_op_mw, jump_state_mw, rdsel_mw, next_pc_mw, alu_out_mw  out  as *_em  registered pass-through
- mem_rdata_mw  out  XLEN  extended load data; 0 for non-loads
- misalign_mw  out  1  access was misaligned and was not issued
- stall_memory  out  1  stall request to the state machine

## Operation
- An access is an op with LOAD_BIT or STORE_BIT set (STORE_BIT takes precedence if both are set).
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
- FSM states:
  - IDLE
    - On phase_memory with an aligned access: capture address, we, be, and wdata into the bus registers; capture the pass-through fields; go to BUSY.
    - On phase_memory with a non-access or misaligned op: load the mw latch directly and stay in IDLE. misalign_mw is 1 only for the misaligned case, and no request is issued.
  - BUSY
    - dmem_req is held at 1 and all bus outputs are held stable.
    - On dmem_ack: load the mw latch (mem_rdata_mw from dmem_rdata), drop the request, return to IDLE.
    - phase_memory is ignored while in BUSY.
- Store lanes:
  - Byte: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
  - Half: wdata={2{rs2[15:0]}}, be=4'b0011<<addr[1:0].
  - Word: wdata=rs2, be=4'b1111.
- Load extraction:
  - Compute sh = dmem_rdata >> (8*addr[1:0]).
  - Byte: sign- or zero-extend sh[7:0].
  - Half: sign- or zero-extend sh[15:0].
  - Word: use dmem_rdata as-is.
  - Loads use be=4'b1111 and we=0.
- Stores and non-access ops write mem_rdata_mw=0.
- Pass-through fields are captured at phase_memory, so later changes on the *_em inputs do not affect an in-flight access.

## Timing
- Reset: state IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata = 0; all *_mw outputs = 0; misalign_mw = 0.
- stall_memory is combinational. It is 1 when:
  - in IDLE, phase_memory=1 and the op is an aligned access, or
  - in BUSY and dmem_ack=0.
- Cycle P is the cycle phase_memory is sampled. dmem_req rises after edge P and is first visible in cycle P+1.
- dmem_ack is sampled only while dmem_req=1.
- With an ack in cycle P+1+W (W wait cycles):
  - the mw latch updates at the end of that cycle;
  - dmem_req falls in the next cycle;
  - minimum latency is 2 cycles.
- An ack arriving while in IDLE is ignored.
- Non-access and misaligned ops: the mw latch updates at the end of cycle P; 1-cycle latency; stall_memory stays 0.
- Asserting rst_n=0 during BUSY immediately drops dmem_req and clears all state. The bus must tolerate an abandoned request.

## Test plan
- lw, addr 0x100, ack after W=3, rdata 0xDEADBEEF → dmem_req high for 4 cycles, addr 0x100, be 1111, stall_memory 1 from P through the cycle before ack, mem_rdata_mw=0xDEADBEEF.
- lb, addr 0x103, rdata 0x80123456 → mem_rdata_mw=0xFFFFFF80; same with lbu → 0x00000080; lh at 0x102 → 0xFFFF8012.
- sh, addr 0x102, rs2=0x1234ABCD, W=0 → dmem_we=1, be=1100, wdata=0xABCDABCD, addr 0x100, mem_rdata_mw=0, latency 2.
- lw at 0x102 → no dmem_req, stall_memory=0, misalign_mw=1 after 1 cycle; a following aligned sw proceeds normally with misalign_mw=0.
- Non-access op, alu_out 0x55, rdsel 7, jump_state 1 → mw latch shows 0x55/7/1 next cycle, dmem_req never asserts; a phase_memory pulse during BUSY does not change any bus output.
- rst_n pulsed low in BUSY (W pending) → dmem_req=0 and all *_mw=0 immediately; a late ack is ignored; the next access completes normally.
